eth_arp_tx: RTL and testbench

Transmit-side ARP reply generator for the Ethernet datapath. When the packet-type arbiter selects ARP and pulses its start strobe, this block latches the requester's MAC/IP and the station's own MAC/IP. It then emits one complete ARP reply frame (no FCS; the MAC appends CRC) as a 32-bit big-endian packet stream toward the MAC TX port. Its `o_ready` level is the arbiter's ARP ready input: low while a frame is in flight, rising again when the frame has been fully accepted.

---
 rtl/eth_arp_tx.sv | 137 +++++++++++++
 tb/tb_eth_arp_tx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/eth_arp_tx.sv
// eth_arp_tx: builds one ARP reply frame per start strobe and streams it as
// 32-bit big-endian words toward the MAC TX port. Rev 1.0
`default_nettype none

module eth_arp_tx #(
  parameter int PAD_TO_60 = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [47:0] i_self_mac,
  input  logic [31:0] i_self_ip,
  input  logic [47:0] i_req_mac,
  input  logic [31:0] i_req_ip,
  output logic [31:0] o_tx_data,
  output logic        o_tx_sop,
  output logic        o_tx_eop,
  output logic        o_tx_vld,
  output logic [1:0]  o_tx_empty,
  input  logic        i_tx_rdy,
  output logic        o_ready
);

  localparam logic [3:0] c_LAST = (PAD_TO_60 != 0) ? 4'd14 : 4'd10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_wcnt, w_wcnt_nxt;
  logic        w_latch;
  logic [47:0] r_self_mac, r_req_mac, w_self_mac, w_req_mac;
  logic [31:0] r_self_ip, r_req_ip, w_self_ip, w_req_ip;
  logic [31:0] w_word;
  logic        w_send_nxt;
  logic        w_eop_nxt;

  function automatic logic [31:0] f_word(
    input logic [3:0]  idx,
    input logic [47:0] smac,
    input logic [31:0] sip,
    input logic [47:0] rmac,
    input logic [31:0] rip
  );
    logic [31:0] w;
    w = 32'h0;
    case (idx)
      4'd0:    w = rmac[47:16];
      4'd1:    w = {rmac[15:0], smac[47:32]};
      4'd2:    w = smac[31:0];
      4'd3:    w = 32'h0806_0001;
      4'd4:    w = 32'h0800_0604;
      4'd5:    w = {16'h0002, smac[47:32]};
      4'd6:    w = smac[31:0];
      4'd7:    w = sip;
      4'd8:    w = rmac[47:16];
      4'd9:    w = {rmac[15:0], rip[31:16]};
      4'd10:   w = {rip[15:0], 16'h0000};
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_latch     = 1'b0;
    if (r_state == ST_IDLE) begin
      if (i_start) begin
        w_latch     = 1'b1;
        w_state_nxt = ST_SEND;
        w_wcnt_nxt  = 4'd0;
      end
    end else if (i_tx_rdy) begin
      // In SEND the registered valid is always high, so rdy alone means accepted
      if (r_wcnt == c_LAST) begin
        w_state_nxt = ST_IDLE;
        w_wcnt_nxt  = 4'd0;
      end else begin
        w_wcnt_nxt  = r_wcnt + 4'd1;
      end
    end
  end

  // Outputs are registered, so the next word is built from next-cycle values,
  // taking the live inputs on the cycle they are latched.
  assign w_self_mac = w_latch ? i_self_mac : r_self_mac;
  assign w_self_ip  = w_latch ? i_self_ip  : r_self_ip;
  assign w_req_mac  = w_latch ? i_req_mac  : r_req_mac;
  assign w_req_ip   = w_latch ? i_req_ip   : r_req_ip;
  assign w_word     = f_word(w_wcnt_nxt, w_self_mac, w_self_ip, w_req_mac, w_req_ip);
  assign w_send_nxt = (w_state_nxt == ST_SEND);
  assign w_eop_nxt  = w_send_nxt && (w_wcnt_nxt == c_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_wcnt  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_self_mac <= 48'h0;
      r_self_ip  <= 32'h0;
      r_req_mac  <= 48'h0;
      r_req_ip   <= 32'h0;
      o_tx_data  <= 32'h0;
      o_tx_sop   <= 1'b0;
      o_tx_eop   <= 1'b0;
      o_tx_vld   <= 1'b0;
      o_tx_empty <= 2'd0;
      o_ready    <= 1'b1;
    end else begin
      if (w_latch) begin
        r_self_mac <= i_self_mac;
        r_self_ip  <= i_self_ip;
        r_req_mac  <= i_req_mac;
        r_req_ip   <= i_req_ip;
      end
      o_tx_data  <= w_send_nxt ? w_word : 32'h0;
      o_tx_sop   <= w_send_nxt && (w_wcnt_nxt == 4'd0);
      o_tx_eop   <= w_eop_nxt;
      o_tx_vld   <= w_send_nxt;
      o_tx_empty <= (w_eop_nxt && (PAD_TO_60 == 0)) ? 2'd2 : 2'd0;
      o_ready    <= !w_send_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_eth_arp_tx.sv
// tb_eth_arp_tx: scoreboard bench for eth_arp_tx, padded and bare instances
// driven from shared stimulus. Rev 1.0
`default_nettype none

module tb_eth_arp_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start;
  logic [47:0] i_self_mac, i_req_mac;
  logic [31:0] i_self_ip, i_req_ip;
  logic        i_tx_rdy;
  logic [31:0] tx_data[2];
  logic        tx_sop[2], tx_eop[2], tx_vld[2], rdy_o[2];
  logic [1:0]  tx_empty[2];

  always #5 clk = ~clk;

  eth_arp_tx #(.PAD_TO_60(1)) u_pad (
    .clk(clk), .rst_n(rst_n), .i_start(i_start),
    .i_self_mac(i_self_mac), .i_self_ip(i_self_ip),
    .i_req_mac(i_req_mac), .i_req_ip(i_req_ip),
    .o_tx_data(tx_data[0]), .o_tx_sop(tx_sop[0]), .o_tx_eop(tx_eop[0]),
    .o_tx_vld(tx_vld[0]), .o_tx_empty(tx_empty[0]),
    .i_tx_rdy(i_tx_rdy), .o_ready(rdy_o[0])
  );

  eth_arp_tx #(.PAD_TO_60(0)) u_bare (
    .clk(clk), .rst_n(rst_n), .i_start(i_start),
    .i_self_mac(i_self_mac), .i_self_ip(i_self_ip),
    .i_req_mac(i_req_mac), .i_req_ip(i_req_ip),
    .o_tx_data(tx_data[1]), .o_tx_sop(tx_sop[1]), .o_tx_eop(tx_eop[1]),
    .o_tx_vld(tx_vld[1]), .o_tx_empty(tx_empty[1]),
    .i_tx_rdy(i_tx_rdy), .o_ready(rdy_o[1])
  );

  typedef struct packed {
    logic [31:0] d;
    logic        sop;
    logic        eop;
    logic [1:0]  emp;
  } exp_t;

  exp_t        q[2][$];
  exp_t        prev[2];
  bit          held[2];
  int          widx[2];
  int          errors = 0;
  int          checks = 0;
  bit          bp_mode = 1'b0;
  logic [31:0] wa[11], wb[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: pops one expected word per accepted beat, and checks hold under backpressure
  always @(negedge clk) begin
    exp_t a, e;
    for (int i = 0; i < 2; i++) begin
      a = {tx_data[i], tx_sop[i], tx_eop[i], tx_empty[i]};
      if (!rst_n) begin
        held[i] = 1'b0;
        widx[i] = 0;
      end else begin
        if (held[i])
          chk($sformatf("hold_dut%0d", i), {tx_vld[i], a}, {1'b1, prev[i]});
        if (tx_vld[i] && i_tx_rdy) begin
          if (q[i].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word_dut%0d: got %h expected none", i, a);
          end else begin
            e = q[i].pop_front();
            chk($sformatf("word%0d_dut%0d", widx[i], i), a, e);
            widx[i] = e.eop ? 0 : widx[i] + 1;
          end
        end
        held[i] = tx_vld[i] && !i_tx_rdy;
        prev[i] = a;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      i_tx_rdy = bp_mode ? ~i_tx_rdy : 1'b1;
    end
  end

  task automatic set_addr(input bit useb);
    if (!useb) begin
      i_self_mac = 48'h0011_2233_4455; i_self_ip = 32'hC0A8_010A;
      i_req_mac  = 48'hAABB_CCDD_EEFF; i_req_ip  = 32'hC0A8_0101;
    end else begin
      i_self_mac = 48'h0200_0000_0001; i_self_ip = 32'h0A00_0001;
      i_req_mac  = 48'h1234_5678_9ABC; i_req_ip  = 32'h0A00_0002;
    end
  endtask

  task automatic push_frame(input bit useb);
    exp_t e;
    logic [31:0] w;
    for (int i = 0; i < 15; i++) begin
      w = (i < 11) ? (useb ? wb[i] : wa[i]) : 32'h0;
      e.d = w; e.sop = (i == 0); e.eop = (i == 14); e.emp = 2'd0;
      q[0].push_back(e);
      if (i < 11) begin
        e.eop = (i == 10); e.emp = (i == 10) ? 2'd2 : 2'd0;
        q[1].push_back(e);
      end
    end
  endtask

  task automatic start(input bit useb);
    set_addr(useb);
    push_frame(useb);
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!(rdy_o[0] && rdy_o[1]) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, {63'h0, rdy_o[0] & rdy_o[1]}, 64'h1);
  endtask

  task automatic q_empty(input string name);
    chk(name, q[0].size() + q[1].size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int v;
    wa = '{32'hAABBCCDD, 32'hEEFF0011, 32'h22334455, 32'h08060001, 32'h08000604,
           32'h00020011, 32'h22334455, 32'hC0A8010A, 32'hAABBCCDD, 32'hEEFFC0A8,
           32'h01010000};
    wb = '{32'h12345678, 32'h9ABC0200, 32'h00000001, 32'h08060001, 32'h08000604,
           32'h00020200, 32'h00000001, 32'h0A000001, 32'h12345678, 32'h9ABC0A00,
           32'h00020000};
    rst_n = 1'b0; i_start = 1'b0; i_tx_rdy = 1'b1;
    i_self_mac = '0; i_self_ip = '0; i_req_mac = '0; i_req_ip = '0;

    repeat (3) @(posedge clk); #1;
    for (int i = 0; i < 2; i++)
      chk($sformatf("reset_outs_dut%0d", i),
          {rdy_o[i], tx_vld[i], tx_sop[i], tx_eop[i], tx_empty[i], tx_data[i]},
          {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0});
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic frame with cycle-exact ready timing on the padded instance
    start(0);
    chk("ready_low_n1", {63'h0, rdy_o[0]}, 64'h0);
    chk("sop_vld_n1", {tx_vld[0], tx_sop[0]}, 2'b11);
    repeat (14) @(posedge clk); #1;
    chk("eop_ready_n15", {rdy_o[0], tx_eop[0]}, 2'b01);
    @(posedge clk); #1;
    chk("ready_high_n16", {63'h0, rdy_o[0]}, 64'h1);
    q_empty("basic_q_empty");

    bp_mode = 1'b1;
    start(0);
    wait_idle("bp_idle");
    bp_mode = 1'b0;
    @(posedge clk); #1;
    q_empty("bp_q_empty");

    // Start strobe while busy must be dropped
    start(0);
    repeat (5) @(posedge clk); #1;
    i_req_mac = 48'h0102_0304_0506;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    set_addr(0);
    wait_idle("busy_idle");
    v = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_vld[0] || tx_vld[1]) v++;
    end
    chk("no_second_frame", v, 0);
    q_empty("busy_q_empty");
    @(posedge clk); #1;

    // Address inputs change after the start strobe
    start(0);
    repeat (2) @(posedge clk); #1;
    i_req_ip = 32'hDEADBEEF; i_req_mac = 48'h1111_2222_3333;
    i_self_mac = 48'h4444_5555_6666; i_self_ip = 32'h7777_8888;
    wait_idle("chg_idle");
    set_addr(0);
    q_empty("chg_q_empty");

    // Reset in the middle of a frame, then a fresh frame with new addresses
    start(0);
    repeat (7) @(posedge clk); #1;
    chk("pre_reset_word7", tx_data[0], wa[7]);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++)
      chk($sformatf("async_reset_dut%0d", i),
          {tx_vld[i], tx_sop[i], tx_eop[i], rdy_o[i]}, 4'b0001);
    q[0].delete();
    q[1].delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    start(1);
    chk("post_reset_sop", {tx_vld[0], tx_sop[0], tx_data[0]}, {2'b11, wb[0]});
    wait_idle("post_reset_idle");
    q_empty("post_reset_q_empty");

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
